// File: rtl/tmr_pwm_out_pkg.sv
// Shared types for the PWM output stage: control word layout, FSM states,
// reference-edge decode and per-state drive levels.
package pkg_sfrs_definition;

  localparam int PWM_CTRL_W = 32;

  // Field bit positions inside pwm_ctrl (en in bit 0).
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_POL_BIT     = 1;
  localparam int CTRL_ONESHOT_BIT = 2;
  localparam int CTRL_FLT_EN_BIT  = 3;
  localparam int CTRL_FIELDS_W    = 4;

  typedef struct packed {
    logic [PWM_CTRL_W-5:0] reserved;
    logic                  flt_en;
    logic                  oneshot;
    logic                  pol;
    logic                  en;
  } pwm_ctrl_t;

  typedef enum logic [2:0] {
    IDLE,
    INACTIVE,
    DT_RISE,
    ACTIVE,
    DT_FALL,
    DONE,
    FAULT
  } pwm_state_t;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } ref_edge_t;

  // match1 clears the reference, so it wins when both matches coincide.
  function automatic ref_edge_t decode_edge(input logic m0, input logic m1);
    ref_edge_t e;
    e = EDGE_NONE;
    if (m1) begin
      e = EDGE_FALL;
    end else if (m0) begin
      e = EDGE_RISE;
    end
    return e;
  endfunction

  // States in which the output stage is actively following the timer.
  function automatic logic is_running(input pwm_state_t s);
    return (s == INACTIVE) || (s == DT_RISE) || (s == ACTIVE) || (s == DT_FALL);
  endfunction

  // High-side level before polarity.
  function automatic logic drive_h(input pwm_state_t s);
    return (s == ACTIVE);
  endfunction

  // Low-side level before polarity.
  function automatic logic drive_l(input pwm_state_t s);
    return (s == INACTIVE);
  endfunction

endpackage

// File: rtl/tmr_pwm_out_if.sv
// Control, timer-event and drive signals of the PWM output stage.
interface tmr_pwm_out_if #(
  parameter int DT_W       = 8,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] pwm_ctrl;
  logic [DT_W-1:0]       dt_val;
  logic                  match0_event;
  logic                  match1_event;
  logic                  ovf_event;
  logic                  pwm_flt;
  logic                  pwm_h;
  logic                  pwm_l;
  logic                  pwm_busy;
  logic                  prd_pulse;
  logic                  flt_sts;

  modport master (
    output pwm_ctrl, dt_val, match0_event, match1_event, ovf_event, pwm_flt,
    input  pwm_h, pwm_l, pwm_busy, prd_pulse, flt_sts
  );

  modport slave (
    input  pwm_ctrl, dt_val, match0_event, match1_event, ovf_event, pwm_flt,
    output pwm_h, pwm_l, pwm_busy, prd_pulse, flt_sts
  );
endinterface

// File: rtl/tmr_pwm_out_dt_cnt.sv
// Dead-time down-counter: load has priority over clear, then it counts to 0.
module tmr_pwm_dt_cnt #(
  parameter int DT_W = 8
) (
  input  logic            tmr_clk,
  input  logic            sys_rst_n,
  input  logic            load,
  input  logic [DT_W-1:0] load_val,
  input  logic            clr,
  output logic            cnt_zero,
  output logic            cnt_one
);
  logic [DT_W-1:0] r_cnt;

  // Count register: load, clear, or decrement toward zero.
  always_ff @(posedge tmr_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt_zero = (r_cnt == '0);
  assign cnt_one  = (r_cnt == DT_W'(1));
endmodule

// File: rtl/tmr_pwm_out.sv
// Complementary PWM output stage with dead-time insertion, fault latch and
// one-shot support, driven by registered timer match/overflow events.
module tmr_pwm_out
  import pkg_sfrs_definition::*;
#(
  parameter int DT_W       = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic          tmr_clk,
  input logic          sys_rst_n,
  tmr_pwm_out_if.slave bus
);
  logic [CTRL_FIELDS_W-1:0] w_ctrl_bits;
  logic       w_en, w_pol, w_oneshot, w_flt_en;
  ref_edge_t  w_edge;
  logic       w_dt_zero;
  logic       w_cnt_load, w_cnt_clr, w_cnt_zero, w_cnt_one;
  pwm_state_t r_state, w_state_next;
  logic       r_pwm_h, r_pwm_l, r_prd_pulse, r_flt_sts;

  // Only the low control bits carry fields; narrow words are zero-extended.
  generate
    if (DATA_WIDTH >= CTRL_FIELDS_W) begin : g_ctrl_full
      assign w_ctrl_bits = bus.pwm_ctrl[CTRL_FIELDS_W-1:0];
    end else begin : g_ctrl_narrow
      assign w_ctrl_bits = {{(CTRL_FIELDS_W-DATA_WIDTH){1'b0}}, bus.pwm_ctrl};
    end
  endgenerate

  assign w_en      = w_ctrl_bits[CTRL_EN_BIT];
  assign w_pol     = w_ctrl_bits[CTRL_POL_BIT];
  assign w_oneshot = w_ctrl_bits[CTRL_ONESHOT_BIT];
  assign w_flt_en  = w_ctrl_bits[CTRL_FLT_EN_BIT];
  assign w_edge    = decode_edge(bus.match0_event, bus.match1_event);
  assign w_dt_zero = (bus.dt_val == '0);

  tmr_pwm_dt_cnt #(.DT_W(DT_W)) u_dt_cnt (
    .tmr_clk   (tmr_clk),
    .sys_rst_n (sys_rst_n),
    .load      (w_cnt_load),
    .load_val  (bus.dt_val),
    .clr       (w_cnt_clr),
    .cnt_zero  (w_cnt_zero),
    .cnt_one   (w_cnt_one)
  );

  // Next-state decode: fault beats disable beats one-shot end beats edges.
  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = 1'b0;
    if (w_flt_en && bus.pwm_flt) begin
      w_state_next = FAULT;
    end else if (r_state == FAULT) begin
      if (!w_en) w_state_next = IDLE;
    end else if (!w_en) begin
      w_state_next = IDLE;
    end else if (w_oneshot && bus.ovf_event && is_running(r_state)) begin
      w_state_next = DONE;
    end else begin
      case (r_state)
        IDLE: w_state_next = INACTIVE;
        INACTIVE: begin
          if (w_edge == EDGE_RISE) begin
            if (w_dt_zero) begin
              w_state_next = ACTIVE;
            end else begin
              w_state_next = DT_RISE;
              w_cnt_load   = 1'b1;
            end
          end
        end
        DT_RISE: begin
          // h never asserted, so a fall here needs no dead-time.
          if (w_edge == EDGE_FALL) w_state_next = INACTIVE;
          else if (w_cnt_one || w_cnt_zero) w_state_next = ACTIVE;
        end
        ACTIVE: begin
          if (w_edge == EDGE_FALL) begin
            if (w_dt_zero) begin
              w_state_next = INACTIVE;
            end else begin
              w_state_next = DT_FALL;
              w_cnt_load   = 1'b1;
            end
          end
        end
        DT_FALL: begin
          if (w_edge == EDGE_RISE) w_state_next = ACTIVE;
          else if (w_cnt_one || w_cnt_zero) w_state_next = INACTIVE;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // Counter is parked at zero whenever no dead-time interval is running.
  assign w_cnt_clr = (w_state_next != DT_RISE) && (w_state_next != DT_FALL);

  // State register.
  always_ff @(posedge tmr_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  // Output registers: drive levels of the next state, polarity applied.
  always_ff @(posedge tmr_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pwm_h     <= 1'b0;
      r_pwm_l     <= 1'b0;
      r_prd_pulse <= 1'b0;
      r_flt_sts   <= 1'b0;
    end else begin
      r_pwm_h     <= drive_h(w_state_next) ^ w_pol;
      r_pwm_l     <= drive_l(w_state_next) ^ w_pol;
      r_prd_pulse <= bus.ovf_event && is_running(r_state);
      r_flt_sts   <= (w_state_next == FAULT);
    end
  end

  assign bus.pwm_h     = r_pwm_h;
  assign bus.pwm_l     = r_pwm_l;
  assign bus.prd_pulse = r_prd_pulse;
  assign bus.flt_sts   = r_flt_sts;
  assign bus.pwm_busy  = is_running(r_state);
endmodule

// File: tb/tb_tmr_pwm_out.sv
// Directed plus randomized bench for tmr_pwm_out against a level/timer model.
module tb_tmr_pwm_out;
  localparam int DT_W       = 8;
  localparam int DATA_WIDTH = 32;

  localparam int M_OFF   = 0;
  localparam int M_RUN   = 1;
  localparam int M_DONE  = 2;
  localparam int M_FAULT = 3;

  logic tmr_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  tmr_pwm_out_if #(.DT_W(DT_W), .DATA_WIDTH(DATA_WIDTH)) bus ();

  tmr_pwm_out #(.DT_W(DT_W), .DATA_WIDTH(DATA_WIDTH)) dut (
    .tmr_clk   (tmr_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 tmr_clk = ~tmr_clk;

  // Stimulus variables.
  logic t_en, t_pol, t_one, t_flten, t_m0, t_m1, t_ovf, t_flt;
  int   t_dt;

  // Model: mode, reference level, internal drive levels, pending dead-time.
  int   m_mode, m_wait;
  logic m_ref, m_h, m_l, m_live, m_pol_last;
  logic exp_h, exp_l, exp_prd, exp_flt, exp_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic apply();
    pkg_sfrs_definition::pwm_ctrl_t c;
    c         = '0;
    c.en      = t_en;
    c.pol     = t_pol;
    c.oneshot = t_one;
    c.flt_en  = t_flten;
    bus.pwm_ctrl     = c;
    bus.dt_val       = DT_W'(t_dt);
    bus.match0_event = t_m0;
    bus.match1_event = t_m1;
    bus.ovf_event    = t_ovf;
    bus.pwm_flt      = t_flt;
  endtask

  task automatic check(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, expv);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_OFF; m_wait = 0; m_ref = 1'b0; m_h = 1'b0; m_l = 1'b0;
    m_live = 1'b0; m_pol_last = 1'b0;
    exp_h = 1'b0; exp_l = 1'b0; exp_prd = 1'b0; exp_flt = 1'b0; exp_busy = 1'b0;
  endfunction

  // Advance a pending dead-time; when it expires the wanted side turns on.
  function automatic void wait_tick();
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        if (m_ref) m_h = 1'b1;
        else       m_l = 1'b1;
      end
    end
  endfunction

  function automatic void model_step(input logic rst_n, en, pol, one, flten,
                                     m0, m1, ovf, flt, input int dt);
    exp_prd = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_mode == M_RUN && ovf) exp_prd = 1'b1;
    if (flten && flt) begin
      m_mode = M_FAULT; m_h = 1'b0; m_l = 1'b0; m_wait = 0;
    end else if (m_mode == M_FAULT) begin
      if (!en) m_mode = M_OFF;
    end else if (!en) begin
      m_mode = M_OFF; m_h = 1'b0; m_l = 1'b0; m_wait = 0;
    end else if (m_mode == M_OFF) begin
      m_mode = M_RUN; m_ref = 1'b0; m_h = 1'b0; m_l = 1'b1; m_wait = 0;
    end else if (m_mode == M_RUN) begin
      if (one && ovf) begin
        m_mode = M_DONE; m_h = 1'b0; m_l = 1'b0; m_wait = 0;
      end else if (m1 && m_ref) begin
        m_ref = 1'b0;
        if (m_h) begin
          m_h = 1'b0; m_wait = dt; m_l = (dt == 0);
        end else begin
          m_l = 1'b1; m_wait = 0;
        end
      end else if (m0 && !m1 && !m_ref) begin
        m_ref = 1'b1;
        if (m_l) begin
          m_l = 1'b0; m_wait = dt; m_h = (dt == 0);
        end else begin
          m_h = 1'b1; m_wait = 0;
        end
      end else begin
        wait_tick();
      end
    end
    exp_h      = m_h ^ pol;
    exp_l      = m_l ^ pol;
    exp_flt    = (m_mode == M_FAULT);
    exp_busy   = (m_mode == M_RUN);
    m_live     = 1'b1;
    m_pol_last = pol;
  endfunction

  task automatic check_outputs();
    logic ovl;
    check("pwm_h", bus.pwm_h, exp_h);
    check("pwm_l", bus.pwm_l, exp_l);
    check("prd_pulse", bus.prd_pulse, exp_prd);
    check("flt_sts", bus.flt_sts, exp_flt);
    check("pwm_busy", bus.pwm_busy, exp_busy);
    if (m_live) begin
      ovl = (bus.pwm_h ^ m_pol_last) & (bus.pwm_l ^ m_pol_last);
      check("no_overlap", ovl, 1'b0);
    end
  endtask

  task automatic tick();
    logic s_rst;
    apply();
    s_rst = sys_rst_n;
    @(posedge tmr_clk);
    cyc++;
    model_step(s_rst, t_en, t_pol, t_one, t_flten, t_m0, t_m1, t_ovf, t_flt, t_dt);
    @(negedge tmr_clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    t_en = 0; t_pol = 0; t_one = 0; t_flten = 0;
    t_m0 = 0; t_m1 = 0; t_ovf = 0; t_flt = 0; t_dt = 3;
    model_reset();
    apply();
    #1;
    check_outputs();
    ticks(2);

    // Basic dead-time: dt=3, pol=0.
    sys_rst_n = 1'b1;
    t_en = 1;
    ticks(9);
    check("inactive_l", bus.pwm_l, 1'b1);
    t_m0 = 1; tick(); t_m0 = 0;
    check("dt_l_fall", bus.pwm_l, 1'b0);
    check("dt_h_held", bus.pwm_h, 1'b0);
    ticks(2);
    check("dt_h_wait", bus.pwm_h, 1'b0);
    tick();
    check("dt_h_rise", bus.pwm_h, 1'b1);
    ticks(16);
    t_m1 = 1; tick(); t_m1 = 0;
    check("dt_h_fall", bus.pwm_h, 1'b0);
    ticks(2);
    check("dt_l_wait", bus.pwm_l, 1'b0);
    tick();
    check("dt_l_rise", bus.pwm_l, 1'b1);

    // Zero dead-time: both sides swap on one edge.
    t_dt = 0;
    t_m0 = 1; tick(); t_m0 = 0;
    check("zdt_h", bus.pwm_h, 1'b1);
    check("zdt_l", bus.pwm_l, 1'b0);
    t_m1 = 1; tick(); t_m1 = 0;
    check("zdt_back_l", bus.pwm_l, 1'b1);

    // Reversal during rising dead-time.
    t_dt = 5;
    t_m0 = 1; tick(); t_m0 = 0;
    tick();
    t_m1 = 1; tick(); t_m1 = 0;
    check("rev_l_back", bus.pwm_l, 1'b1);
    check("rev_h_never", bus.pwm_h, 1'b0);
    ticks(6);

    // Simultaneous matches from ACTIVE count as a fall.
    t_dt = 0;
    t_m0 = 1; tick(); t_m0 = 0;
    t_m0 = 1; t_m1 = 1; tick(); t_m0 = 0; t_m1 = 0;
    check("simul_fall", bus.pwm_h, 1'b0);

    // Fault in ACTIVE, then release through en=0.
    t_dt = 2;
    t_m0 = 1; tick(); t_m0 = 0;
    ticks(3);
    t_flten = 1; t_flt = 1; tick(); t_flt = 0;
    check("flt_h", bus.pwm_h, 1'b0);
    check("flt_l", bus.pwm_l, 1'b0);
    check("flt_sts_set", bus.flt_sts, 1'b1);
    t_m0 = 1; tick(); t_m0 = 0;
    check("flt_hold", bus.flt_sts, 1'b1);
    t_en = 0; tick();
    check("flt_clear", bus.flt_sts, 1'b0);
    t_en = 1; tick();
    t_flten = 0;

    // One-shot with active-low outputs.
    t_pol = 1; t_one = 1; t_dt = 1;
    tick();
    t_m0 = 1; tick(); t_m0 = 0;
    tick();
    check("os_active_h", bus.pwm_h, 1'b0);
    t_ovf = 1; tick(); t_ovf = 0;
    check("os_prd", bus.prd_pulse, 1'b1);
    check("os_done_h", bus.pwm_h, 1'b1);
    check("os_done_l", bus.pwm_l, 1'b1);
    t_ovf = 1; tick(); t_ovf = 0;
    check("os_no_prd", bus.prd_pulse, 1'b0);
    t_m1 = 1; tick(); t_m1 = 0;
    t_m0 = 1; tick(); t_m0 = 0;
    t_en = 0; tick();
    t_one = 0; t_en = 1; tick();

    // Asynchronous reset in the middle of a rising dead-time.
    t_dt = 6;
    t_m0 = 1; tick(); t_m0 = 0;
    tick();
    #2;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_h", bus.pwm_h, 1'b0);
    check_outputs();
    @(negedge tmr_clk);
    tick();
    sys_rst_n = 1'b1;
    tick();
    check("rst_inactive_l", bus.pwm_l, 1'b0);
    check("rst_inactive_h", bus.pwm_h, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if (t_en && $urandom_range(0, 59) == 0) t_en = 0;
      else if (!t_en && $urandom_range(0, 3) == 0) t_en = 1;
      if ($urandom_range(0, 39) == 0) t_pol = ~t_pol;
      if ($urandom_range(0, 49) == 0) t_one = ~t_one;
      if ($urandom_range(0, 59) == 0) t_flten = ~t_flten;
      if ($urandom_range(0, 24) == 0) t_dt = int'($urandom_range(0, 6));
      t_m0  = ($urandom_range(0, 6) == 0);
      t_m1  = ($urandom_range(0, 6) == 0);
      t_ovf = ($urandom_range(0, 11) == 0);
      t_flt = ($urandom_range(0, 50) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
